// File: rtl/regfile_write_arbiter_if.sv
// Requester-side write bus for the register-file write arbiter.
// Handshake: a requester raises req_valid[i] with stable req_addr/req_data
// slices; a transfer happens on the rising edge where req_valid[i] and
// req_ready[i] are both high. Addr/data must not change while valid is high
// and ready is low; after a transfer the requester may drop valid or present
// the next write.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  // Requesters drive valid/addr/data and observe ready.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // The arbiter observes valid/addr/data and drives ready.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_REQ writeback requesters. The winning write is registered onto the
// port (one cycle of latency). A per-register busy scoreboard is set by the
// issue stage's reservations and cleared when the write to that register is
// committed by the register file.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int NREGS     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  output logic                  reserve_ok,
  output logic [NREGS-1:0]      busy,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [IDW-1:0]        grant_id
);

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  reg_write_q;
  logic [ADDR_WIDTH-1:0] write_reg_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic [IDW-1:0]        grant_id_q;
  logic [NREGS-1:0]      busy_q, busy_d;

  logic                  grant_any;
  logic [IDW-1:0]        grant_idx;
  logic [NUM_REQ-1:0]    ready;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Split the flattened requester buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search from ptr upwards (wrapping); first valid requester wins.
  // No grant is given while reset is high.
  always_comb begin
    int            idx;
    logic [IDW-1:0] idx_v;
    grant_any  = 1'b0;
    grant_idx  = '0;
    ready      = '0;
    grant_addr = '0;
    grant_data = '0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = IDW'(idx);
      if (!reset && !grant_any && bus.req_valid[idx_v]) begin
        grant_any    = 1'b1;
        grant_idx    = idx_v;
        ready[idx_v] = 1'b1;
        grant_addr   = addr_arr[idx_v];
        grant_data   = data_arr[idx_v];
      end
    end
  end

  // Pointer moves just past the requester that won this cycle.
  always_comb begin
    if (grant_idx == IDW'(NUM_REQ - 1)) ptr_d = '0;
    else                                ptr_d = grant_idx + 1'b1;
  end

  // Reservation is refused while the register is still busy, including the
  // cycle in which its pending write is being committed.
  assign reserve_ok = reserve_valid & ~busy_q[reserve_addr] & ~reset;

  // Scoreboard next state: clear on commit, then set on reservation so a
  // same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    if (reserve_ok)  busy_d[reserve_addr] = 1'b1;
  end

  // Pointer, output stage and scoreboard registers; reset drops any held write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q <= grant_any;
      busy_q      <= busy_d;
      if (grant_any) begin
        ptr_q        <= ptr_d;
        write_reg_q  <= grant_addr;
        write_data_q <= grant_data;
        grant_id_q   <= grant_idx;
      end
    end
  end

  assign bus.req_ready = ready;
  assign busy          = busy_q;
  assign reg_write     = reg_write_q;
  assign write_reg     = write_reg_q;
  assign write_data    = write_data_q;
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: the driver pushes each expected
// register-file write into a queue; a negedge monitor pops and compares
// whenever reg_write is high. Combinational outputs and the scoreboard are
// checked directly by the driver at the negedge.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int IDW     = 2;
  localparam int W       = IDW + AW + DW;

  logic          clk;
  logic          reset;
  logic          reserve_valid;
  logic [AW-1:0] reserve_addr;
  logic          reserve_ok;
  logic [15:0]   busy;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [IDW-1:0] grant_id;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .reserve_ok    (reserve_ok),
    .busy          (busy),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .grant_id      (grant_id)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic expect_write(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({id, a, d});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got id=%0d reg=%0h data=%0h, expected no write", grant_id, write_reg, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_id",   32'(grant_id),   32'(mon_e[W-1 -: IDW]));
        check("write_reg",  32'(write_reg),  32'(mon_e[DW +: AW]));
        check("write_data", 32'(write_data), 32'(mon_e[DW-1:0]));
      end
    end
  end

  initial begin
    // Reset state, with requests/reservation asserted to prove gating
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    reserve_valid = 1'b1;
    reserve_addr  = 4'd0;
    sample();
    check("rst_reg_write",  32'(reg_write),  0);
    check("rst_write_reg",  32'(write_reg),  0);
    check("rst_write_data", 32'(write_data), 0);
    check("rst_grant_id",   32'(grant_id),   0);
    check("rst_busy",       32'(busy),       0);
    check("rst_req_ready",  32'(bus.req_ready), 0);
    check("rst_reserve_ok", 32'(reserve_ok), 0);
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = 4'b0000;
    reserve_valid = 1'b0;

    // Single write from requester 0
    next_cycle();
    bus.req_valid = 4'b0001;
    set_req(0, 4'd3, 8'hA5);
    expect_write(2'd0, 4'd3, 8'hA5);
    sample();
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = 4'b0000;
    sample();
    check("t1_ready_idle", 32'(bus.req_ready), 0);
    check("t1_reg_write",  32'(reg_write), 1);
    next_cycle();
    sample();
    check("t1_reg_write_low", 32'(reg_write), 0);

    // Grant to 3 moves ptr to 0, then all four requesting for 8 cycles
    next_cycle();
    bus.req_valid = 4'b1000;
    set_req(3, 4'hE, 8'h3E);
    expect_write(2'd3, 4'hE, 8'h3E);
    sample();
    check("t2_pre_ready", 32'(bus.req_ready), 32'h8);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'(k + i), DW'(k * 16 + i));
      expect_write(IDW'(order[k]), AW'(k + order[k]), DW'(k * 16 + order[k]));
      sample();
      check("t2_ready", 32'(bus.req_ready), 32'(1) << order[k]);
      check("t2_reg_write", 32'(reg_write), 1);
    end
    next_cycle();
    bus.req_valid = 4'b0000;
    sample();
    check("t2_reg_write_last", 32'(reg_write), 1);
    next_cycle();
    sample();
    check("t2_reg_write_low", 32'(reg_write), 0);

    // ptr=2 after a grant to 1; requesters 0 and 1 served with no bubble
    next_cycle();
    bus.req_valid = 4'b0010;
    set_req(1, 4'd1, 8'h31);
    expect_write(2'd1, 4'd1, 8'h31);
    sample();
    check("t3_ready_a", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = 4'b0011;
    set_req(0, 4'd2, 8'h20);
    set_req(1, 4'd4, 8'h41);
    expect_write(2'd0, 4'd2, 8'h20);
    sample();
    check("t3_ready_b", 32'(bus.req_ready), 32'h1);
    next_cycle();
    expect_write(2'd1, 4'd4, 8'h41);
    sample();
    check("t3_ready_c", 32'(bus.req_ready), 32'h2);
    check("t3_reg_write", 32'(reg_write), 1);
    next_cycle();
    bus.req_valid = 4'b0000;
    sample();
    check("t3_reg_write_b", 32'(reg_write), 1);

    // Reserve 5, duplicate rejected, write clears it, retry after commit
    next_cycle();
    reserve_valid = 1'b1;
    reserve_addr  = 4'd5;
    sample();
    check("t4_reserve_ok", 32'(reserve_ok), 1);
    check("t4_busy_before", 32'(busy), 0);
    next_cycle();
    sample();
    check("t4_busy_set", 32'(busy), 32'h0020);
    check("t4_reserve_dup", 32'(reserve_ok), 0);
    next_cycle();
    reserve_valid = 1'b0;
    bus.req_valid = 4'b0010;
    set_req(1, 4'd5, 8'h55);
    expect_write(2'd1, 4'd5, 8'h55);
    sample();
    check("t4_ready", 32'(bus.req_ready), 32'h2);
    check("t4_busy_held", 32'(busy), 32'h0020);
    next_cycle();
    bus.req_valid = 4'b0000;
    reserve_valid = 1'b1;
    reserve_addr  = 4'd5;
    sample();
    check("t4_reg_write", 32'(reg_write), 1);
    check("t4_reserve_during_clear", 32'(reserve_ok), 0);
    check("t4_busy_during_clear", 32'(busy), 32'h0020);
    next_cycle();
    sample();
    check("t4_busy_cleared", 32'(busy), 0);
    check("t4_reserve_retry", 32'(reserve_ok), 1);
    next_cycle();
    reserve_valid = 1'b0;
    sample();
    check("t4_busy_reset", 32'(busy), 32'h0020);

    // Same edge: commit to unreserved 7 and reserve of 7 -> set wins
    next_cycle();
    bus.req_valid = 4'b0001;
    set_req(0, 4'd7, 8'h77);
    expect_write(2'd0, 4'd7, 8'h77);
    sample();
    check("t5_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = 4'b0000;
    reserve_valid = 1'b1;
    reserve_addr  = 4'd7;
    sample();
    check("t5_reg_write", 32'(reg_write), 1);
    check("t5_reserve_ok", 32'(reserve_ok), 1);
    next_cycle();
    reserve_valid = 1'b0;
    sample();
    check("t5_busy", 32'(busy), 32'h00A0);

    // Handshake taken, then async reset before the next edge discards it
    next_cycle();
    bus.req_valid = 4'b0100;
    set_req(2, 4'd9, 8'h99);
    sample();
    check("t6_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #2;
    bus.req_valid = 4'b0000;
    reset = 1'b1;
    #1;
    check("t6_rst_reg_write",  32'(reg_write),  0);
    check("t6_rst_busy",       32'(busy),       0);
    check("t6_rst_write_reg",  32'(write_reg),  0);
    check("t6_rst_write_data", 32'(write_data), 0);
    check("t6_rst_grant_id",   32'(grant_id),   0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    bus.req_valid = 4'b1111;
    set_req(0, 4'hA, 8'hA0);
    set_req(1, 4'hB, 8'hB1);
    set_req(2, 4'hC, 8'hC2);
    set_req(3, 4'hD, 8'hD3);
    expect_write(2'd0, 4'hA, 8'hA0);
    sample();
    check("t6_ready_first", 32'(bus.req_ready), 32'h1);
    next_cycle();
    expect_write(2'd1, 4'hB, 8'hB1);
    sample();
    check("t6_ready_second", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = 4'b0000;
    sample();
    check("t6_reg_write", 32'(reg_write), 1);
    next_cycle();
    sample();
    check("t6_reg_write_low", 32'(reg_write), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
